// File: rtl/pixel_config_seq.sv
// Frame sequencer for the pixel configuration shift chain: takes 6-bit words over valid/ready,
// shifts each word out with a generated config_clk/config_en pair, and pushes each completed row.
module pixel_config_seq #(
  parameter int unsigned WORDS_PER_ROW = 32,
  parameter int unsigned ROWS          = 128,
  parameter int unsigned CLK_DIV       = 2,
  parameter int unsigned PUSH_LEN      = 4,
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int unsigned WW = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1
) (
  input  logic          clk_40MHz,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [5:0]    word_data,
  input  logic          word_valid,
  output logic          word_ready,
  output logic [5:0]    config_data,
  output logic          config_clk,
  output logic          config_en,
  output logic          push_en,
  output logic          busy,
  output logic          done,
  output logic [RW-1:0] row_idx,
  output logic [WW-1:0] word_idx
);

  localparam int unsigned PMAX = (CLK_DIV > PUSH_LEN) ? CLK_DIV : PUSH_LEN;
  localparam int unsigned PW   = (PMAX > 1) ? $clog2(PMAX) : 1;
  localparam logic [PW-1:0] DIV_LAST  = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PUSH_LAST = PW'(PUSH_LEN - 1);
  localparam logic [WW-1:0] WORD_LAST = WW'(WORDS_PER_ROW - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, SETUP, HIGH, HOLD, PUSH, GAP, DONE
  } state_t;

  state_t        state, state_next;
  logic [PW-1:0] phase;
  logic          div_last, push_last, word_last, row_last, accept;

  assign div_last  = (phase == DIV_LAST);
  assign push_last = (phase == PUSH_LAST);
  assign word_last = (word_idx == WORD_LAST);
  assign row_last  = (row_idx == ROW_LAST);
  assign accept    = (state == LOAD) && word_valid && !abort;

  always_ff @(posedge clk_40MHz or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (start)      state_next = LOAD;
      LOAD:  if (word_valid) state_next = SETUP;
      SETUP: if (div_last)   state_next = HIGH;
      HIGH:  if (div_last)   state_next = HOLD;
      HOLD:  if (div_last)   state_next = word_last ? PUSH : LOAD;
      PUSH:  if (push_last)  state_next = GAP;
      GAP:   if (div_last)   state_next = row_last ? DONE : LOAD;
      DONE:                  state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  // Phase counter restarts on every state change and only runs in the timed states.
  always_ff @(posedge clk_40MHz or posedge rst) begin
    if (rst) begin
      phase <= '0;
    end else if (state_next != state) begin
      phase <= '0;
    end else if (state inside {SETUP, HIGH, HOLD, PUSH, GAP}) begin
      phase <= phase + 1'b1;
    end
  end

  always_ff @(posedge clk_40MHz or posedge rst) begin
    if (rst) begin
      row_idx  <= '0;
      word_idx <= '0;
    end else if (abort || (state == IDLE && start)) begin
      row_idx  <= '0;
      word_idx <= '0;
    end else if (state == HOLD && div_last && !word_last) begin
      word_idx <= word_idx + 1'b1;
    end else if (state == GAP && div_last) begin
      word_idx <= '0;
      if (!row_last) row_idx <= row_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_40MHz or posedge rst) begin
    if (rst)         config_data <= '0;
    else if (abort)  config_data <= '0;
    else if (accept) config_data <= word_data;
  end

  // Strobes are registered decodes of the next state, so each one lines up with its state.
  always_ff @(posedge clk_40MHz or posedge rst) begin
    if (rst) begin
      word_ready <= 1'b0;
      config_clk <= 1'b0;
      config_en  <= 1'b0;
      push_en    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      word_ready <= (state_next == LOAD);
      config_clk <= (state_next == HIGH);
      config_en  <= (state_next inside {SETUP, HIGH, HOLD});
      push_en    <= (state_next == PUSH);
      busy       <= !(state_next inside {IDLE, DONE});
      done       <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_pixel_config_seq.sv
// Self-checking bench for pixel_config_seq: a cycle table for a tiny frame, directed reset/abort
// sequences, and randomized frames checked against an event-level timeline model.
module tb_pixel_config_seq;

  localparam int MAXK = 40000;
  localparam int NW   = 8192;
  localparam logic [5:0] F_READY = 6'b100000;
  localparam logic [5:0] F_EN    = 6'b010000;
  localparam logic [5:0] F_CLK   = 6'b001000;
  localparam logic [5:0] F_PUSH  = 6'b000100;
  localparam logic [5:0] F_BUSY  = 6'b000010;
  localparam logic [5:0] F_DONE  = 6'b000001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, abort, word_valid, sel;
  logic [5:0] word_data;
  logic       start_s, start_d, abort_s, abort_d;
  assign start_s = start & ~sel;
  assign start_d = start & sel;
  assign abort_s = abort & ~sel;
  assign abort_d = abort & sel;

  logic       s_ready, s_clk, s_en, s_push, s_busy, s_done;
  logic [5:0] s_data;
  logic [0:0] s_row, s_word;
  logic       d_ready, d_clk, d_en, d_push, d_busy, d_done;
  logic [5:0] d_data;
  logic [6:0] d_row;
  logic [4:0] d_word;

  pixel_config_seq #(.WORDS_PER_ROW(2), .ROWS(2), .CLK_DIV(1), .PUSH_LEN(2)) dut_s (
    .clk_40MHz(clk), .rst(rst), .start(start_s), .abort(abort_s),
    .word_data(word_data), .word_valid(word_valid), .word_ready(s_ready),
    .config_data(s_data), .config_clk(s_clk), .config_en(s_en), .push_en(s_push),
    .busy(s_busy), .done(s_done), .row_idx(s_row), .word_idx(s_word)
  );

  pixel_config_seq dut_d (
    .clk_40MHz(clk), .rst(rst), .start(start_d), .abort(abort_d),
    .word_data(word_data), .word_valid(word_valid), .word_ready(d_ready),
    .config_data(d_data), .config_clk(d_clk), .config_en(d_en), .push_en(d_push),
    .busy(d_busy), .done(d_done), .row_idx(d_row), .word_idx(d_word)
  );

  logic [5:0] obs_flags, obs_data;
  logic [7:0] obs_row, obs_word;
  always_comb begin
    if (sel) begin
      obs_flags = {d_ready, d_en, d_clk, d_push, d_busy, d_done};
      obs_data  = d_data;
      obs_row   = 8'(d_row);
      obs_word  = 8'(d_word);
    end else begin
      obs_flags = {s_ready, s_en, s_clk, s_push, s_busy, s_done};
      obs_data  = s_data;
      obs_row   = 8'(s_row);
      obs_word  = 8'(s_word);
    end
  end

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [5:0] src_words [NW];
  int         src_idx;
  bit         v_tab [MAXK+1];
  logic [5:0] exp_tl [MAXK+1];

  typedef struct {
    logic       vl;
    logic [5:0] flags;
    logic [5:0] data;
    int         row;
    int         word;
  } vec_t;
  vec_t tbl [24];

  function automatic logic [31:0] obs_pack();
    return {4'b0, obs_flags, obs_data, obs_row, obs_word};
  endfunction

  task automatic check_vec(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Drive one cycle of inputs, advance past the edge, and move the upstream source on a handshake.
  task automatic tick(input logic st, input logic ab, input logic vl);
    logic hs;
    start      = st;
    abort      = ab;
    word_valid = vl;
    word_data  = src_words[src_idx % NW];
    hs = vl & obs_flags[5] & ~ab;
    @(posedge clk);
    #1;
    if (hs) src_idx++;
    start = 1'b0;
    abort = 1'b0;
  endtask

  // mode 0: valid always high; 1: valid dropped for cycles 5..14; 2: random valid.
  task automatic run_frame(input logic which, input int W, input int R, input int D, input int P,
                           input int mode, input bit extra, input bit counting, output int got_done);
    int t, done_k, bad_k, nsamp, samp_bad, npush;
    logic [5:0] bad_got;
    logic prev_clk, prev_push;
    sel = which;
    src_idx = 0;
    for (int i = 0; i < NW; i++) src_words[i] = counting ? 6'(i) : 6'($urandom);
    for (int k = 0; k <= MAXK; k++) begin
      exp_tl[k] = '0;
      case (mode)
        0:       v_tab[k] = 1'b1;
        1:       v_tab[k] = !(k >= 5 && k <= 14);
        default: v_tab[k] = ($urandom_range(0, 2) != 0);
      endcase
    end
    t = 1;
    for (int r = 0; r < R; r++) begin
      for (int w = 0; w < W; w++) begin
        while (!v_tab[t] && t < MAXK - 200) begin
          exp_tl[t] = F_READY | F_BUSY;
          t++;
        end
        exp_tl[t] = F_READY | F_BUSY;
        for (int c = 1; c <= 3 * D; c++)
          exp_tl[t+c] = F_EN | F_BUSY | ((c > D && c <= 2 * D) ? F_CLK : 6'b0);
        t += 3 * D + 1;
      end
      for (int c = 0; c < P; c++) exp_tl[t+c] = F_PUSH | F_BUSY;
      t += P;
      for (int c = 0; c < D; c++) exp_tl[t+c] = F_BUSY;
      t += D;
    end
    done_k = t;
    exp_tl[done_k] = F_DONE;

    tick(1'b1, 1'b0, v_tab[0]);
    prev_clk = 1'b0; prev_push = 1'b0;
    got_done = -1; bad_k = -1; bad_got = '0; nsamp = 0; samp_bad = -1; npush = 0;
    for (int k = 1; k <= done_k + 2; k++) begin
      if (obs_flags !== exp_tl[k] && bad_k < 0) begin
        bad_k = k;
        bad_got = obs_flags;
      end
      if (obs_flags[0] && got_done < 0) got_done = k;
      if (prev_clk && !obs_flags[3]) begin
        if (samp_bad < 0 && (obs_data !== src_words[nsamp % NW] || !obs_flags[4])) samp_bad = nsamp;
        nsamp++;
      end
      if (obs_flags[2] && !prev_push) npush++;
      prev_clk  = obs_flags[3];
      prev_push = obs_flags[2];
      tick(extra && k < done_k && $urandom_range(0, 7) == 0, 1'b0, v_tab[k]);
    end
    n_cmp++;
    if (bad_k >= 0) begin
      n_bad++;
      $display("FAIL timeline: cycle %0d flags %b expected %b", bad_k, bad_got, exp_tl[bad_k]);
    end
    check_int("done_cycle", got_done, done_k);
    check_int("sample_count", nsamp, W * R);
    check_int("first_bad_sample", samp_bad, -1);
    check_int("push_count", npush, R);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, got_done;
    tbl[0]  = '{1'b1, 6'b100010, 6'h00, 0, 0};
    tbl[1]  = '{1'b1, 6'b010010, 6'h01, 0, 0};
    tbl[2]  = '{1'b1, 6'b011010, 6'h01, 0, 0};
    tbl[3]  = '{1'b1, 6'b010010, 6'h01, 0, 0};
    tbl[4]  = '{1'b1, 6'b100010, 6'h01, 0, 1};
    tbl[5]  = '{1'b1, 6'b010010, 6'h02, 0, 1};
    tbl[6]  = '{1'b1, 6'b011010, 6'h02, 0, 1};
    tbl[7]  = '{1'b1, 6'b010010, 6'h02, 0, 1};
    tbl[8]  = '{1'b1, 6'b000110, 6'h02, 0, 1};
    tbl[9]  = '{1'b1, 6'b000110, 6'h02, 0, 1};
    tbl[10] = '{1'b1, 6'b000010, 6'h02, 0, 1};
    tbl[11] = '{1'b1, 6'b100010, 6'h02, 1, 0};
    tbl[12] = '{1'b1, 6'b010010, 6'h03, 1, 0};
    tbl[13] = '{1'b1, 6'b011010, 6'h03, 1, 0};
    tbl[14] = '{1'b1, 6'b010010, 6'h03, 1, 0};
    tbl[15] = '{1'b1, 6'b100010, 6'h03, 1, 1};
    tbl[16] = '{1'b1, 6'b010010, 6'h04, 1, 1};
    tbl[17] = '{1'b1, 6'b011010, 6'h04, 1, 1};
    tbl[18] = '{1'b1, 6'b010010, 6'h04, 1, 1};
    tbl[19] = '{1'b1, 6'b000110, 6'h04, 1, 1};
    tbl[20] = '{1'b1, 6'b000110, 6'h04, 1, 1};
    tbl[21] = '{1'b1, 6'b000010, 6'h04, 1, 1};
    tbl[22] = '{1'b1, 6'b000001, 6'h04, 1, 0};
    tbl[23] = '{1'b1, 6'b000000, 6'h04, 1, 0};

    rst = 1'b1; start = 1'b0; abort = 1'b0; word_valid = 1'b0; word_data = '0; sel = 1'b0;
    src_idx = 0;
    for (int i = 0; i < NW; i++) src_words[i] = '0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    sel = 1'b0; #1 check_vec("reset_small", obs_pack(), 32'h0);
    sel = 1'b1; #1 check_vec("reset_default", obs_pack(), 32'h0);
    sel = 1'b0;
    @(posedge clk); #1;

    // Tiny frame, cycle by cycle
    src_idx = 0;
    for (int i = 0; i < 4; i++) src_words[i] = 6'(i + 1);
    tick(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 24; i++) begin
      check_vec($sformatf("vec_k%0d", i + 1), obs_pack(),
                {4'b0, tbl[i].flags, tbl[i].data, 8'(tbl[i].row), 8'(tbl[i].word)});
      tick(1'b0, 1'b0, tbl[i].vl);
    end

    // Asynchronous reset in the middle of SETUP
    src_idx = 0;
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    check_vec("pre_reset_setup", 32'(obs_flags), 32'(F_EN | F_BUSY));
    #2 rst = 1'b1;
    #1 check_vec("async_reset_outputs", obs_pack(), 32'h0);
    @(posedge clk);
    #3 rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick(1'b0, 1'b0, 1'b1);
      if (obs_flags[3] || obs_flags[1] || obs_flags[4]) cnt++;
    end
    check_int("idle_after_reset_activity", cnt, 0);

    // Abort in the second row's PUSH
    src_idx = 0;
    tick(1'b1, 1'b0, 1'b1);
    for (int k = 1; k < 20; k++) tick(1'b0, 1'b0, 1'b1);
    check_vec("pre_abort_push", {26'b0, obs_flags}, {26'b0, F_PUSH | F_BUSY});
    tick(1'b0, 1'b1, 1'b1);
    check_vec("after_abort", obs_pack(), 32'h0);
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      tick(1'b0, 1'b0, 1'b1);
      if (obs_flags[0] || obs_flags[1]) cnt++;
    end
    check_int("no_done_after_abort", cnt, 0);
    run_frame(1'b0, 2, 2, 1, 2, 0, 1'b0, 1'b0, got_done);
    check_int("frame_after_abort_done", got_done, 23);

    // start and abort together while idle
    tick(1'b1, 1'b1, 1'b1);
    check_vec("start_abort_idle_a", {26'b0, obs_flags}, 32'h0);
    tick(1'b0, 1'b0, 1'b1);
    check_vec("start_abort_idle_b", {26'b0, obs_flags}, 32'h0);

    // Upstream stall of 10 cycles on the second word
    run_frame(1'b0, 2, 2, 1, 2, 1, 1'b0, 1'b0, got_done);
    check_int("stall_done", got_done, 33);

    // Extra start pulses while busy must not change anything
    run_frame(1'b0, 2, 2, 1, 2, 0, 1'b1, 1'b0, got_done);
    check_int("busy_start_done", got_done, 23);

    for (int i = 0; i < 4; i++) run_frame(1'b0, 2, 2, 1, 2, 2, 1'b1, 1'b0, got_done);

    // Full default frame with counting data
    run_frame(1'b1, 32, 128, 2, 4, 0, 1'b1, 1'b1, got_done);
    check_int("default_done", got_done, 29441);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
